// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory arbiter
package mem_arb_pkg;

  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

  // Width of a counter that must hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester and single-port RAM bundle for the memory arbiter
interface mem_arb_if #(
  parameter int ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic              d_err;
  logic [31:0]       d_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  // Environment side: requesters and the RAM itself.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_err, d_rdata,
    input  mem_we, mem_addr, mem_din
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_err, d_rdata,
    output mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between fetch and data
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CW         = cnt_w(STARVE_MAX)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [CW-1:0] starve_cnt,
  output gnt_e          pick
);

  logic starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // Data normally wins; a fetch that has lost STARVE_MAX contests in a row takes the slot.
  always_comb begin
    pick = GNT_NONE;
    if (d_req && !(if_req && starved)) begin
      pick = GNT_D;
    end else if (if_req) begin
      pick = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port RAM
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int ADDR_W     = 32
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  localparam int CW = cnt_w(STARVE_MAX);

  logic [CW-1:0]     starve_cnt;
  gnt_e              pick;
  gnt_e              winner;
  logic              d_misal;
  logic              if_pend;
  logic              d_pend;
  logic              err_q;
  logic [ADDR_W-1:0] addr_sel;

  assign d_misal = (bus.d_addr[1:0] != 2'b00);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CW         (CW)
  ) u_pick (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .starve_cnt (starve_cnt),
    .pick       (pick)
  );

  // Nothing is granted while reset is held, so no read can be left pending across it.
  assign winner = rst ? GNT_NONE : pick;

  // Grant strobes and RAM controls follow the winner in the same cycle.
  always_comb begin
    bus.if_gnt  = 1'b0;
    bus.d_gnt   = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_din = '0;
    addr_sel    = '0;
    case (winner)
      GNT_IF: begin
        bus.if_gnt  = 1'b1;
        addr_sel    = bus.if_addr;
        bus.mem_din = bus.d_wdata;
      end
      GNT_D: begin
        bus.d_gnt   = 1'b1;
        addr_sel    = bus.d_addr;
        bus.mem_we  = bus.d_we & ~d_misal;
        bus.mem_din = bus.d_wdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr = addr_sel;

  // Starvation counter and read-owner/error flags for the access granted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      if_pend    <= 1'b0;
      d_pend     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (winner == GNT_IF) begin
        starve_cnt <= '0;
      end else if (winner == GNT_D && bus.if_req && starve_cnt != CW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if_pend <= (winner == GNT_IF);
      d_pend  <= (winner == GNT_D) && !bus.d_we && !d_misal;
      err_q   <= (winner == GNT_D) && d_misal;
    end
  end

  // Responses are masked during reset so a pre-reset grant never surfaces.
  assign bus.if_rvalid = if_pend & ~rst;
  assign bus.d_rvalid  = d_pend & ~rst;
  assign bus.d_err     = err_q & ~rst;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_dout : 32'h0;
  assign bus.d_rdata   = bus.d_rvalid ? bus.mem_dout : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  typedef struct {
    int          kind;   // 0 fetch read, 1 data read, 2 data error
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int          cyc_n;
  int          checks;
  int          errors;
  exp_t        q[$];
  exp_t        mon_e;
  int          got_kind;
  logic [31:0] got_data;
  logic [31:0] ram [16];

  mem_arb_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(
    .STARVE_MAX (4),
    .ADDR_W     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Synchronous RAM: read data is valid one cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[5:2]] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr[5:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // One bus cycle: drive after the edge, check combinational outputs at the falling edge,
  // and queue the response the granted access must produce next cycle.
  task automatic cyc(input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                     input logic eig, input logic edg, input logic emwe,
                     input logic [31:0] emaddr, input logic [31:0] erd);
    @(posedge clk);
    #1;
    rst         = r;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
    @(negedge clk);
    chk("if_gnt", {31'b0, bus.if_gnt}, {31'b0, eig});
    chk("d_gnt", {31'b0, bus.d_gnt}, {31'b0, edg});
    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, emwe});
    chk("mem_addr", bus.mem_addr, emaddr);
    if (eig) q.push_back('{0, erd, cyc_n + 1});
    if (edg && da[1:0] != 2'b00) q.push_back('{2, 32'h0, cyc_n + 1});
    else if (edg && !dw) q.push_back('{1, erd, cyc_n + 1});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every response strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
      chk("rst_d_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
      chk("rst_d_err", {31'b0, bus.d_err}, 32'h0);
    end else begin
      if (bus.if_rvalid || bus.d_rvalid || bus.d_err) begin
        chk("one_strobe", 32'(bus.if_rvalid) + 32'(bus.d_rvalid) + 32'(bus.d_err), 32'd1);
        if (bus.if_rvalid) begin
          got_kind = 0;
          got_data = bus.if_rdata;
        end else if (bus.d_err) begin
          got_kind = 2;
          got_data = 32'h0;
        end else begin
          got_kind = 1;
          got_data = bus.d_rdata;
        end
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got kind %0d data %h expected none (cycle %0d)",
                   got_kind, got_data, cyc_n);
        end else begin
          mon_e = q.pop_front();
          chk("resp_kind", 32'(got_kind), 32'(mon_e.kind));
          chk("resp_cycle", 32'(cyc_n), 32'(mon_e.cyc));
          chk("resp_data", got_data, mon_e.data);
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc_n) begin
        mon_e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_response: got none expected kind %0d data %h (cycle %0d)",
                 mon_e.kind, mon_e.data, cyc_n);
      end
      if (!bus.if_rvalid) chk("if_rdata_idle", bus.if_rdata, 32'h0);
      if (!bus.d_rvalid) chk("d_rdata_idle", bus.d_rdata, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1);
  end

  initial begin
    cyc_n  = 0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) ram[i] = 32'hA000_0000 | 32'(i);
    ram[2] = 32'h0020_81b3;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;

    // Reset with both requesters live: nothing granted, RAM quiet.
    cyc(1, 1, 32'h08, 1, 1, 32'h08, 32'h1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h08, 1, 0, 32'h08, 32'h0, 0, 0, 0, 0, 0);
    idle();

    // Lone fetch of word 2.
    cyc(0, 1, 32'h08, 0, 0, 0, 0, 1, 0, 0, 32'h08, 32'h0020_81b3);
    idle();

    // Data write then read-back of 0x0C.
    cyc(0, 0, 0, 1, 1, 32'h0C, 32'hDEAD_BEEF, 0, 1, 1, 32'h0C, 0);
    cyc(0, 0, 0, 1, 0, 32'h0C, 32'h0, 0, 1, 0, 32'h0C, 32'hDEAD_BEEF);

    // Misaligned read and write: granted, no RAM write, error next cycle.
    cyc(0, 0, 0, 1, 0, 32'h0E, 32'h0, 0, 1, 0, 32'h0E, 0);
    cyc(0, 0, 0, 1, 1, 32'h0D, 32'h1234_5678, 0, 1, 0, 32'h0D, 0);
    cyc(0, 0, 0, 1, 0, 32'h0C, 32'h0, 0, 1, 0, 32'h0C, 32'hDEAD_BEEF);

    // Misaligned fetch goes to RAM unchanged.
    cyc(0, 1, 32'h0A, 0, 0, 0, 0, 1, 0, 0, 32'h0A, 32'h0020_81b3);
    idle();

    // Contested: four data wins then one fetch, twice over.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) cyc(0, 1, 32'h14, 1, 0, 32'h10, 0, 1, 0, 0, 32'h14, 32'hA000_0005);
      else            cyc(0, 1, 32'h14, 1, 0, 32'h10, 0, 0, 1, 0, 32'h10, 32'hA000_0004);
    end

    // Build up starvation, then reset: the last read's response is swallowed by reset.
    cyc(0, 1, 32'h14, 1, 0, 32'h10, 0, 0, 1, 0, 32'h10, 32'hA000_0004);
    cyc(0, 1, 32'h14, 1, 0, 32'h10, 0, 0, 1, 0, 32'h10, 32'hA000_0004);
    void'(q.pop_back());
    cyc(1, 1, 32'h14, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    idle();

    // Counter must restart from zero: again four data wins before the fetch.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) cyc(0, 1, 32'h14, 1, 0, 32'h10, 0, 1, 0, 0, 32'h14, 32'hA000_0005);
      else        cyc(0, 1, 32'h14, 1, 0, 32'h10, 0, 0, 1, 0, 32'h10, 32'hA000_0004);
    end

    // Fetch granted, reset rises next cycle with fetch still requesting.
    cyc(0, 1, 32'h08, 0, 0, 0, 0, 1, 0, 0, 32'h08, 32'h0020_81b3);
    void'(q.pop_back());
    cyc(1, 1, 32'h08, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("post_rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
    chk("post_rst_d_err", {31'b0, bus.d_err}, 32'h0);

    // Alternating single-requester reads, one access every cycle.
    cyc(0, 1, 32'h00, 0, 0, 0, 0, 1, 0, 0, 32'h00, 32'hA000_0000);
    cyc(0, 0, 0, 1, 0, 32'h04, 0, 0, 1, 0, 32'h04, 32'hA000_0001);
    cyc(0, 1, 32'h08, 0, 0, 0, 0, 1, 0, 0, 32'h08, 32'h0020_81b3);
    cyc(0, 0, 0, 1, 0, 32'h0C, 0, 0, 1, 0, 32'h0C, 32'hDEAD_BEEF);
    cyc(0, 1, 32'h18, 0, 0, 0, 0, 1, 0, 0, 32'h18, 32'hA000_0006);
    cyc(0, 0, 0, 1, 0, 32'h1C, 0, 0, 1, 0, 32'h1C, 32'hA000_0007);

    idle();
    idle();
    idle();
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, giving the consecutive contested cycles fetch may lose before it wins priority.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the byte address width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 if_req  input  1  instruction-fetch read request.
REQ-006 if_addr  input  ADDR_W  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid / if_rdata  output  1 / 32  fetch read-data strobe and word.
REQ-009 d_req, d_we  input  1 each  data request; write when d_we=1, read when d_we=0.
REQ-010 d_addr / d_wdata  input  ADDR_W / 32  data byte address and write word.
REQ-011 d_gnt, d_rvalid, d_err  output  1 each  data accepted, read data valid, misaligned access.
REQ-012 d_rdata  output  32  data read word.
REQ-013 mem_we, mem_addr, mem_din  output  1 / ADDR_W / 32  single-port RAM controls.
REQ-014 mem_dout  input  32  RAM read data, valid one cycle after the address is sampled.

Function
REQ-015 SHALL grant at most one requester per cycle; gnt and mem_* drive combinationally from current req/addr/state.
REQ-016 SHALL require a requester to hold req, addr, we and wdata stable until gnt; no gnt without req.
REQ-017 Priority: data over fetch, unless starve_cnt == STARVE_MAX, in which case fetch SHALL win.
REQ-018 starve_cnt: +1 when both req and data wins; clear on fetch gnt; SHALL saturate at STARVE_MAX; unchanged otherwise.
REQ-019 On a granted access, mem_addr = winner addr and mem_we = (data winner AND d_we), with mem_din = d_wdata.
REQ-020 With no grant, mem_we=0, mem_addr=0 and mem_din=0.
REQ-021 Granted read: the owner's rvalid SHALL pulse exactly the next cycle with rdata = mem_dout (1-cycle latency).
REQ-022 Read-pending flags record the read owner; back-to-back grants SHALL be allowed, sustaining 1 access/cycle.
REQ-023 Writes complete at gnt and SHALL produce no rvalid.
REQ-024 A data access with d_addr[1:0] != 0 SHALL be granted with mem_we=0.
REQ-025 That misaligned access SHALL produce d_err pulsed the next cycle and no d_rvalid.
REQ-026 A fetch with if_addr[1:0] != 0 SHALL be passed to RAM unchanged.
REQ-027 if_rdata/d_rdata SHALL be 0 when the corresponding rvalid is 0.

Reset
REQ-028 While rst=1: all gnt, rvalid, d_err and mem_we SHALL be 0.
REQ-029 While rst=1: starve_cnt and pending flags SHALL clear.
REQ-030 No rvalid/err SHALL appear in the cycle after reset deasserts, including for a request live when rst rose.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the grant enum (GNT_NONE, GNT_IF, GNT_D) and the default STARVE_MAX.
REQ-032 A combinational sub-module mem_arb_pick SHALL compute the winner from reqs and starve_cnt.
REQ-033 Counters, pending flags and error flag SHALL live in mem_arbiter.

Verification
REQ-034 RAM word 2 = 002081b3; if_req, if_addr=0x08 alone -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=002081b3.
REQ-035 d_req write 0xDEADBEEF @0x0C, then read @0x0C -> d_gnt both cycles, no rvalid after write, d_rvalid + d_rdata=DEADBEEF after read.
REQ-036 if_req and d_req (read) held continuously -> d_gnt 4 cycles, if_gnt on 5th, repeating pattern.
REQ-037 d_req read @0x0E -> d_gnt, mem_we=0, next cycle d_err=1, d_rvalid=0.
REQ-038 Fetch read granted with rst rising same cycle -> if_rvalid stays 0; starve_cnt=0 after reset.
REQ-039 Alternating fetch/data reads every cycle -> each rvalid one cycle after its gnt, to correct owner, no drops.
